// File: rtl/regfile_nw2r.sv
// -----------------------------------------------------------------------------
// regfile_nw2r
//   Parametrised register file: DEPTH = 2**ADDR_W registers of DATA_W bits.
//   One write port with address decode gated by write enable, two independent
//   read ports with registered (1-cycle) outputs and write-first forwarding,
//   and a multi-cycle hardware clear sequencer that zeroes every register.
//
// Ports
//   clk     : single clock, all state changes on the rising edge
//   reset   : synchronous, active-high reset; overrides everything
//   we      : write enable (ignored while the clear sequence runs)
//   wAddr   : write address
//   wData   : write data
//   rAddr0  : read port 0 address
//   rAddr1  : read port 1 address
//   rData0  : read port 0 data, registered
//   rData1  : read port 1 data, registered
//   clr     : start the clear sequence (sampled only when not busy)
//   busy    : high for exactly DEPTH cycles while the clear sequence runs
//
// Optional build macro
//   REGFILE_R0_ZERO_EN : register 0 is hardwired to zero; writes to address 0
//                        are discarded and every read of address 0 returns 0,
//                        including the forwarding path.
// -----------------------------------------------------------------------------
module regfile_nw2r #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddr0,
  input  logic [ADDR_W-1:0] rAddr1,
  output logic [DATA_W-1:0] rData0,
  output logic [DATA_W-1:0] rData1,
  input  logic              clr,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] regs [DEPTH];

  // Effective write for this cycle: the external port in IDLE, the clear
  // sweep (address = counter, data = 0) in CLEAR.
  logic              ew;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] ed;
  logic [DEPTH-1:0]  wsel;
  logic [DATA_W-1:0] rd0_next;
  logic [DATA_W-1:0] rd1_next;

  // NOTE: every combinational output gets a default at the top of the block so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ew = we;
    ea = wAddr;
    ed = wData;
    if (state == CLEAR) begin
      ew = 1'b1;
      ea = clr_cnt;
      ed = '0;
    end
  end

  // One-hot write select: decode(ea) gated by ew.
  always_comb begin
    wsel = '0;
    if (ew) wsel[ea] = 1'b1;
`ifdef REGFILE_R0_ZERO_EN
    wsel[0] = 1'b0;
`endif
  end

  // Write-first read mux: a read of the address being written this cycle
  // returns the incoming data rather than the stale register contents.
  function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] val;
    val = (ew && (ea == ra)) ? ed : regs[ra];
`ifdef REGFILE_R0_ZERO_EN
    if (ra == '0) val = '0;
`endif
    return val;
  endfunction

  always_comb begin
    rd0_next = read_mux(rAddr0);
    rd1_next = read_mux(rAddr1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage array is reset explicitly because the block's
      // contract is that every register reads 0 after reset; most memories
      // are left unreset and would not carry this loop.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      rData0  <= '0;
      rData1  <= '0;
      busy    <= 1'b0;
      clr_cnt <= '0;
      state   <= IDLE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wsel[i]) regs[i] <= ed;
      end
      rData0 <= rd0_next;
      rData1 <= rd1_next;

      case (state)
        IDLE: begin
          // A we in the same cycle as clr is still performed above; the sweep
          // then overwrites it.
          if (clr) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          // clr is not examined here, so it can neither restart nor extend
          // the sweep.
          if (clr_cnt == LAST_ADDR) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_nw2r.sv
module tb_regfile_nw2r;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef REGFILE_R0_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] wAddr = '0;
  logic [DATA_W-1:0] wData = '0;
  logic [ADDR_W-1:0] rAddr0 = '0;
  logic [ADDR_W-1:0] rAddr1 = '0;
  logic [DATA_W-1:0] rData0;
  logic [DATA_W-1:0] rData1;
  logic              clr = 1'b0;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  regfile_nw2r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .wAddr  (wAddr),
    .wData  (wData),
    .rAddr0 (rAddr0),
    .rAddr1 (rAddr1),
    .rData0 (rData0),
    .rData1 (rData1),
    .clr    (clr),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a plain array plus "clear cycles remaining" count.
  // ---------------------------------------------------------------------------
  int          m_mem [DEPTH];
  int          m_r0 = 0;
  int          m_r1 = 0;
  int          m_left = 0;
  bit          m_valid = 1'b0;

  function automatic int m_read(input bit w, input int a, input int d, input int ra);
    if (ZERO_EN && ra == 0) return 0;
    if (w && a == ra) return d;
    return m_mem[ra];
  endfunction

  always @(posedge clk) begin
    bit w;
    int a, d;
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_r0 = 0; m_r1 = 0; m_left = 0; m_valid = 1'b1;
    end else begin
      if (m_left > 0) begin
        w = 1'b1; a = DEPTH - m_left; d = 0;
      end else begin
        w = we; a = int'(wAddr); d = int'(wData);
      end
      m_r0 = m_read(w, a, d, int'(rAddr0));
      m_r1 = m_read(w, a, d, int'(rAddr1));
      if (w && !(ZERO_EN && a == 0)) m_mem[a] = d;
      if (m_left > 0) m_left--;
      else if (clr) m_left = DEPTH;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_rData0", 32'(rData0), 32'(m_r0));
      check("cmp_rData1", 32'(rData1), 32'(m_r1));
      check("cmp_busy",   32'(busy),   32'(m_left > 0));
    end
  end

  // Inputs change just after a falling edge; one call = one rising edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    we = 1'b1; wAddr = ADDR_W'(a); wData = DATA_W'(d);
    cyc(1);
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset hold.
    cyc(2);
    reset = 1'b0;
    check("reset_rData0", 32'(rData0), 32'h0);
    check("reset_rData1", 32'(rData1), 32'h0);
    check("reset_busy",   32'(busy),   32'h0);

    // Basic write then read with 1-cycle latency.
    wr(5, 8'hA5);
    rAddr0 = 3'd5;
    cyc(1);
    check("basic_rd5", 32'(rData0), 32'hA5);
    for (int i = 0; i < DEPTH; i++) begin
      rAddr0 = ADDR_W'(i); rAddr1 = ADDR_W'(i);
      cyc(1);
      check("basic_sweep", 32'(rData1), (i == 5) ? 32'hA5 : 32'h0);
    end

    // Same-cycle forwarding on both ports.
    wr(3, 8'h11);
    rAddr0 = 3'd3; rAddr1 = 3'd3;
    we = 1'b1; wAddr = 3'd3; wData = 8'h22;
    cyc(1);
    we = 1'b0;
    check("fwd_p0", 32'(rData0), 32'h22);
    check("fwd_p1", 32'(rData1), 32'h22);

    // Write decode isolation.
    for (int i = 0; i < DEPTH; i++) wr(i, 8'h10 + i);
    for (int i = 0; i < DEPTH; i++) begin
      rAddr0 = ADDR_W'(i); rAddr1 = ADDR_W'(DEPTH - 1 - i);
      cyc(1);
      check("iso_p0", 32'(rData0), (ZERO_EN && i == 0) ? 32'h0 : 32'(8'h10 + i));
      check("iso_p1", 32'(rData1), 32'(8'h10 + DEPTH - 1 - i));
    end
    we = 1'b0; wAddr = 3'd2; wData = 8'hFF; rAddr0 = 3'd2;
    cyc(1);
    cyc(1);
    check("we0_hold", 32'(rData0), 32'h12);

    // Clear sweep: dropped write, ignored second clr, forwarding of zeros.
    rAddr0 = 3'd2; rAddr1 = 3'd6;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      we    = (n <= 3);
      wAddr = 3'd6; wData = 8'h77;
      clr   = (n == 4);
      cyc(1);
    end
    we = 1'b0; clr = 1'b0;
    check("clear_busy_cycles", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      rAddr0 = ADDR_W'(i); rAddr1 = ADDR_W'(i);
      cyc(1);
      check("clear_zero", 32'(rData0), 32'h0);
    end

    // Reset in the middle of a clear.
    for (int i = 0; i < DEPTH; i++) wr(i, 8'hC0 + i);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("midrst_busy",   32'(busy),   32'h0);
    check("midrst_rData0", 32'(rData0), 32'h0);
    check("midrst_rData1", 32'(rData1), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      rAddr0 = ADDR_W'(i); rAddr1 = ADDR_W'(DEPTH - 1 - i);
      cyc(1);
      check("midrst_zero", 32'(rData0), 32'h0);
    end
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("reclr_busy", 32'(busy), 32'h1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      cyc(1);
    end
    check("reclr_cycles", 32'(n), 32'(DEPTH));

    // Register 0 behaviour (hardwired zero only with the optional macro).
    rAddr0 = 3'd0;
    we = 1'b1; wAddr = 3'd0; wData = 8'h5A;
    cyc(1);
    we = 1'b0;
    check("r0_fwd",  32'(rData0), ZERO_EN ? 32'h0 : 32'h5A);
    cyc(1);
    check("r0_hold", 32'(rData0), ZERO_EN ? 32'h0 : 32'h5A);

    // clr and we together: the write happens, then the sweep wipes it.
    rAddr0 = 3'd4;
    we = 1'b1; wAddr = 3'd4; wData = 8'h99; clr = 1'b1;
    cyc(1);
    we = 1'b0; clr = 1'b0;
    check("clrwe_fwd", 32'(rData0), 32'h99);
    cyc(DEPTH + 1);
    check("clrwe_wiped", 32'(rData0), 32'h0);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
